// File: rtl/ring_renderer.sv
// Annulus pixel shader with optional pulsing radius; 2-cycle pixel pipeline, radii change only on frame_tick.
// Define RING_FILL_EN to add a fill_color port for pixels strictly inside the inner radius.
module ring_renderer #(
  parameter int WIDTH    = 96,
  parameter int HEIGHT   = 64,
  parameter int IDX_W    = 13,
  parameter int COLOR_W  = 16,
  parameter int CX       = 48,
  parameter int CY       = 32,
  parameter int R_IN     = 12,
  parameter int R_OUT    = 14,
  parameter int R_MAX    = 30,
  parameter int STEP_DIV = 4
) (
  input  logic               clk25,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   pixel_index,
  input  logic [COLOR_W-1:0] color_in,
`ifdef RING_FILL_EN
  input  logic [COLOR_W-1:0] fill_color,
`endif
  input  logic               frame_tick,
  input  logic               pulse_mode,
  output logic [COLOR_W-1:0] color,
  output logic               busy_anim
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int DW    = IDX_W + 1;
  localparam int SW    = 2 * IDX_W;
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {ST_STATIC, ST_GROW, ST_SHRINK} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] r_in_q, r_out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [SW-1:0]    r_in2_q, r_out2_q;

  // Radius animation: everything advances only on a frame_tick cycle.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STATIC;
      r_in_q  <= IDX_W'(R_IN);
      r_out_q <= IDX_W'(R_OUT);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (frame_tick) begin
      unique case (state_q)
        ST_STATIC: begin
          r_in_q  <= IDX_W'(R_IN);
          r_out_q <= IDX_W'(R_OUT);
          cnt_q   <= '0;
          if (pulse_mode) begin
            state_q <= ST_GROW;
            busy_q  <= 1'b1;
          end
        end
        ST_GROW, ST_SHRINK: begin
          if (!pulse_mode) begin
            state_q <= ST_STATIC;
            busy_q  <= 1'b0;
            r_in_q  <= IDX_W'(R_IN);
            r_out_q <= IDX_W'(R_OUT);
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(STEP_DIV - 1)) begin
            cnt_q <= '0;
            if (state_q == ST_GROW) begin
              r_in_q  <= r_in_q + 1'b1;
              r_out_q <= r_out_q + 1'b1;
              if (r_out_q == IDX_W'(R_MAX - 1)) state_q <= ST_SHRINK;
            end else begin
              r_in_q  <= r_in_q - 1'b1;
              r_out_q <= r_out_q - 1'b1;
              if (r_in_q == IDX_W'(R_IN + 1)) state_q <= ST_GROW;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_STATIC;
      endcase
    end
  end

  // Squares lag the radii by one cycle so a whole frame sees one consistent pair.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_in2_q  <= SW'(R_IN * R_IN);
      r_out2_q <= SW'(R_OUT * R_OUT);
    end else begin
      r_in2_q  <= r_in_q * r_in_q;
      r_out2_q <= r_out_q * r_out_q;
    end
  end

  logic [IDX_W-1:0]     x_d, y_d;
  logic signed [DW-1:0] dx_d, dy_d;
  logic                 in_range_d;

  assign x_d        = pixel_index % IDX_W'(WIDTH);
  assign y_d        = pixel_index / IDX_W'(WIDTH);
  assign dx_d       = DW'($signed({1'b0, x_d}) - CX);
  assign dy_d       = DW'($signed({1'b0, y_d}) - CY);
  assign in_range_d = (int'(pixel_index) < NPIX);

  logic signed [DW-1:0] dx_q, dy_q;
  logic                 in_range_q, v1_q;
  logic [COLOR_W-1:0]   col1_q;
`ifdef RING_FILL_EN
  logic [COLOR_W-1:0]   fill1_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      dx_q       <= '0;
      dy_q       <= '0;
      in_range_q <= 1'b0;
      v1_q       <= 1'b0;
      col1_q     <= '0;
`ifdef RING_FILL_EN
      fill1_q    <= '0;
`endif
    end else begin
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      in_range_q <= in_range_d;
      v1_q       <= 1'b1;
      col1_q     <= color_in;
`ifdef RING_FILL_EN
      fill1_q    <= fill_color;
`endif
    end
  end

  logic [IDX_W-1:0]   adx, ady;
  logic [SW-1:0]      dx2, dy2;
  logic [SW:0]        d2;
  logic [COLOR_W-1:0] shade_d, color_q;

  assign adx = dx_q[DW-1] ? IDX_W'(-dx_q) : IDX_W'(dx_q);
  assign ady = dy_q[DW-1] ? IDX_W'(-dy_q) : IDX_W'(dy_q);
  assign dx2 = adx * adx;
  assign dy2 = ady * ady;
  assign d2  = {1'b0, dx2} + {1'b0, dy2};

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    shade_d = '0;
    if (v1_q && in_range_q) begin
      if (d2 >= {1'b0, r_in2_q} && d2 <= {1'b0, r_out2_q}) shade_d = col1_q;
`ifdef RING_FILL_EN
      else if (d2 < {1'b0, r_in2_q}) shade_d = fill1_q;
`endif
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) color_q <= '0;
    else        color_q <= shade_d;
  end

  assign color     = color_q;
  assign busy_anim = busy_q;

endmodule
